// File: rtl/icache_tag_ctrl_pkg.sv
// icache_tag_ctrl_pkg
//   Shared definitions for the icache tag controller: controller state
//   encoding and helpers that locate the fields inside a tag RAM word
//   (valid bit on top, tag below it).
package icache_tag_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } tag_state_e;

  // Index of the valid bit inside a tag word of width dw.
  function automatic int unsigned tag_valid_bit(input int unsigned dw);
    return dw - 1;
  endfunction

  // Number of tag bits inside a tag word of width dw.
  function automatic int unsigned tag_field_width(input int unsigned dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl
//   Front end of the instruction-cache tag RAM. After reset it sweeps every
//   set to invalid (INIT), then arbitrates flush > refill > lookup, issuing
//   at most one tag RAM access per cycle. A flush re-runs the sweep and
//   acknowledges with a one-cycle pulse. Lookups are pipelined: the read is
//   issued in the grant cycle and the hit is resolved against the RAM data
//   one cycle later.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   flush_req_i / flush_ack_o       level flush request / completion pulse
//   lookup_req_i/_addr_i/_tag_i     lookup request
//   lookup_gnt_o                    lookup accepted this cycle
//   lookup_rvalid_o / lookup_hit_o  lookup result (one cycle after grant)
//   refill_req_i/_addr_i/_tag_i     install a valid tag
//   refill_gnt_o                    refill accepted this cycle
//   tag_req_o/_write_o/_addr_o/_wdata_o, tag_rdata_i   tag RAM port
//   busy_o                          high while sweeping (INIT or FLUSH)
module icache_tag_ctrl
  import icache_tag_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [DATA_WIDTH-2:0] lookup_tag_i,
  output logic                  lookup_gnt_o,
  output logic                  lookup_rvalid_o,
  output logic                  lookup_hit_o,
  input  logic                  refill_req_i,
  input  logic [ADDR_WIDTH-1:0] refill_addr_i,
  input  logic [DATA_WIDTH-2:0] refill_tag_i,
  output logic                  refill_gnt_o,
  output logic                  tag_req_o,
  output logic                  tag_write_o,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic [DATA_WIDTH-1:0] tag_wdata_o,
  input  logic [DATA_WIDTH-1:0] tag_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned VB = tag_valid_bit(DATA_WIDTH);
  localparam int unsigned TW = tag_field_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_SET = '1;

  tag_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  rvalid_q;
  logic                  ack_q;
  logic [TW-1:0]         tag_q;

  logic idle, sweep, flush_go;

  assign idle  = (state_q == ST_IDLE);
  assign sweep = ~idle;

  // The requester keeps flush_req_i high through the ack cycle; masking it
  // with the ack stops the same request from starting a second sweep.
  assign flush_go = idle & flush_req_i & ~ack_q;

  assign refill_gnt_o = idle & ~flush_go & refill_req_i;
  assign lookup_gnt_o = idle & ~flush_go & ~refill_req_i & lookup_req_i;

  // Single RAM port mux; all fields are zero when nothing is issued.
  always_comb begin
    tag_req_o   = 1'b0;
    tag_write_o = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;
    if (sweep) begin
      tag_req_o   = 1'b1;
      tag_write_o = 1'b1;
      tag_addr_o  = cnt_q;
    end else if (refill_gnt_o) begin
      tag_req_o   = 1'b1;
      tag_write_o = 1'b1;
      tag_addr_o  = refill_addr_i;
      tag_wdata_o = {1'b1, refill_tag_i};
    end else if (lookup_gnt_o) begin
      tag_req_o   = 1'b1;
      tag_addr_o  = lookup_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      ack_q    <= 1'b0;
      // Lookup pipeline runs independently of the FSM so a lookup granted
      // just before a flush still returns its result.
      rvalid_q <= lookup_gnt_o;
      if (lookup_gnt_o) tag_q <= lookup_tag_i;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SET) state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SET) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (flush_go) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flush_ack_o     = ack_q;
  assign lookup_rvalid_o = rvalid_q;
  assign lookup_hit_o    = rvalid_q & tag_rdata_i[VB] & (tag_rdata_i[TW-1:0] == tag_q);
  assign busy_o          = sweep;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb_icache_tag_ctrl
//   Directed bench for icache_tag_ctrl with a behavioural tag RAM (one-cycle
//   read latency). Inputs change 1 time unit after the rising edge; outputs
//   are sampled on the falling edge.
module tb_icache_tag_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush_req_i, flush_ack_o;
  logic       lookup_req_i, lookup_gnt_o, lookup_rvalid_o, lookup_hit_o;
  logic [5:0] lookup_addr_i;
  logic [5:0] lookup_tag_i;
  logic       refill_req_i, refill_gnt_o;
  logic [5:0] refill_addr_i;
  logic [5:0] refill_tag_i;
  logic       tag_req_o, tag_write_o;
  logic [5:0] tag_addr_o;
  logic [6:0] tag_wdata_o;
  logic [6:0] tag_rdata_i;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  logic [6:0] mem [64];

  icache_tag_ctrl #(.DATA_WIDTH(7), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_tag_i(lookup_tag_i), .lookup_gnt_o(lookup_gnt_o),
    .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
    .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
    .refill_tag_i(refill_tag_i), .refill_gnt_o(refill_gnt_o),
    .tag_req_o(tag_req_o), .tag_write_o(tag_write_o),
    .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o),
    .tag_rdata_i(tag_rdata_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag RAM model: synchronous write, registered read.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 7'h7F;
    tag_rdata_i = '0;
  end
  always @(posedge clk) begin
    if (tag_req_o) begin
      if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
      else             tag_rdata_i     <= mem[tag_addr_o];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // 64 sweep cycles writing zero to sets 0..63 with no grants and no ack,
  // then IDLE with busy low and nothing issued.
  task automatic init_sweep(input string nm);
    for (int i = 0; i < 64; i++) begin
      sample();
      chk(nm, 32'({busy_o, tag_req_o, tag_write_o, tag_wdata_o, tag_addr_o,
                   flush_ack_o, lookup_gnt_o, refill_gnt_o}),
              32'({3'b111, 7'h00, 6'(i), 3'b000}));
      if (i == 63) begin
        refill_req_i = 1'b0;
        lookup_req_i = 1'b0;
      end
      tick();
    end
    sample();
    chk({nm, "_idle"}, 32'({busy_o, tag_req_o, flush_ack_o}), 32'(3'b000));
  endtask

  initial begin
    rst_n = 1'b0;
    flush_req_i = 1'b0;
    lookup_req_i = 1'b0; lookup_addr_i = '0; lookup_tag_i = '0;
    refill_req_i = 1'b0; refill_addr_i = '0; refill_tag_i = '0;

    #2;
    chk("rst", 32'({busy_o, tag_req_o, tag_write_o, tag_addr_o, lookup_rvalid_o,
                    flush_ack_o, lookup_gnt_o, refill_gnt_o}),
               32'({3'b111, 6'd0, 4'b0000}));

    // INIT sweep; requests held high to confirm nothing is granted.
    tick();
    rst_n = 1'b1;
    refill_req_i = 1'b1; refill_addr_i = 6'd3; refill_tag_i = 6'h01;
    lookup_req_i = 1'b1;
    init_sweep("init");

    // Refill then hit / miss lookups on set 5.
    tick();
    refill_req_i = 1'b1; refill_addr_i = 6'd5; refill_tag_i = 6'h2A;
    sample();
    chk("rf_gnt", 32'({refill_gnt_o, lookup_gnt_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o}),
                  32'({4'b1011, 6'd5, 7'h6A}));
    tick();
    refill_req_i = 1'b0;
    lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 6'h2A;
    sample();
    chk("lk_gnt", 32'({lookup_gnt_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o, lookup_rvalid_o}),
                  32'({3'b110, 6'd5, 7'h00, 1'b0}));
    tick();
    lookup_tag_i = 6'h2B;
    sample();
    chk("lk_hit", 32'({lookup_rvalid_o, lookup_hit_o, lookup_gnt_o}), 32'(3'b111));
    tick();
    lookup_req_i = 1'b0;
    sample();
    chk("lk_miss", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(2'b10));
    tick();
    sample();
    chk("lk_quiet", 32'({lookup_rvalid_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o}), 32'(0));

    // Refill and lookup together: refill wins, lookup follows.
    tick();
    refill_req_i = 1'b1; refill_addr_i = 6'd7; refill_tag_i = 6'h11;
    lookup_req_i = 1'b1; lookup_addr_i = 6'd7; lookup_tag_i = 6'h11;
    sample();
    chk("arb_rf", 32'({refill_gnt_o, lookup_gnt_o, tag_write_o, tag_addr_o, tag_wdata_o}),
                  32'({3'b101, 6'd7, 7'h51}));
    tick();
    refill_req_i = 1'b0;
    sample();
    chk("arb_lk", 32'({refill_gnt_o, lookup_gnt_o, tag_write_o, tag_addr_o}), 32'({3'b010, 6'd7}));
    tick();
    lookup_req_i = 1'b0;
    sample();
    chk("arb_hit", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(2'b11));

    // Lookup just before a flush still returns; flush beats refill.
    tick();
    lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 6'h2A;
    sample();
    chk("pre_fl_gnt", 32'(lookup_gnt_o), 32'(1));
    tick();
    lookup_req_i = 1'b0;
    flush_req_i  = 1'b1;
    refill_req_i = 1'b1; refill_addr_i = 6'd9; refill_tag_i = 6'h03;
    sample();
    chk("fl_smp", 32'({lookup_rvalid_o, lookup_hit_o, busy_o, tag_req_o, refill_gnt_o,
                       lookup_gnt_o, flush_ack_o}), 32'(7'b1100000));
    tick();
    refill_req_i = 1'b0;
    for (int k = 0; k < 64; k++) begin
      sample();
      chk("fl_sweep", 32'({busy_o, tag_req_o, tag_write_o, tag_wdata_o, tag_addr_o,
                           flush_ack_o, refill_gnt_o}),
                      32'({3'b111, 7'h00, 6'(k), 2'b00}));
      tick();
    end
    sample();
    chk("fl_ack", 32'({flush_ack_o, busy_o, tag_req_o}), 32'(3'b100));
    tick();
    flush_req_i = 1'b0;
    lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 6'h2A;
    sample();
    chk("fl_ack_pulse", 32'({flush_ack_o, busy_o, lookup_gnt_o}), 32'(3'b001));
    tick();
    lookup_addr_i = 6'd7; lookup_tag_i = 6'h11;
    sample();
    chk("fl_miss5", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(2'b10));
    tick();
    lookup_req_i = 1'b0;
    sample();
    chk("fl_miss7", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(2'b10));

    // Back-to-back lookups over every set. Set 10 holds the matching tag,
    // set 11 holds a valid but different tag.
    tick();
    refill_req_i = 1'b1; refill_addr_i = 6'd10; refill_tag_i = 6'h05;
    sample();
    chk("b2b_rf10", 32'(refill_gnt_o), 32'(1));
    tick();
    refill_addr_i = 6'd11;
    sample();
    chk("b2b_rf11", 32'(refill_gnt_o), 32'(1));
    tick();
    refill_req_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic [1:0] exp_rv;
      lookup_req_i  = 1'b1;
      lookup_addr_i = 6'(i);
      lookup_tag_i  = 6'(i) ^ 6'h0F;
      exp_rv = (i == 0) ? 2'b00 : {1'b1, (i - 1 == 10)};
      sample();
      chk("b2b_gnt", 32'({lookup_gnt_o, tag_req_o, tag_write_o, tag_addr_o}), 32'({3'b110, 6'(i)}));
      chk("b2b_rv", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(exp_rv));
      tick();
    end
    lookup_req_i = 1'b0;
    sample();
    chk("b2b_last", 32'({lookup_rvalid_o, lookup_hit_o}), 32'(2'b10));
    tick();
    sample();
    chk("b2b_end", 32'(lookup_rvalid_o), 32'(0));

    // Reset in the middle of a flush: sweep restarts from set 0, no ack.
    tick();
    flush_req_i = 1'b1;
    sample();
    chk("rfl_smp", 32'(tag_req_o), 32'(0));
    tick();
    for (int k = 0; k < 30; k++) begin
      sample();
      chk("rfl_sweep", 32'({busy_o, tag_addr_o}), 32'({1'b1, 6'(k)}));
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({busy_o, tag_write_o, tag_addr_o, flush_ack_o, lookup_rvalid_o,
                        refill_gnt_o, lookup_gnt_o}), 32'({2'b11, 6'd0, 4'b0000}));
    flush_req_i = 1'b0;
    rst_n = 1'b1;
    init_sweep("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
